// File: rtl/rr_mux_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rr_mux_pkg
// Description : Shared constants and helpers for the rr_mux channel
//               multiplexer (mode encodings, round-robin pointer wrap).
// Revision    : 1.0 - initial release
// ============================================================================
package rr_mux_pkg;

    // Encoding of the rr_mux `mode` input
    localparam logic MODE_ARB   = 1'b0;
    localparam logic MODE_FORCE = 1'b1;

    // Advance a channel index by one, wrapping at the channel count
    function automatic int unsigned rr_wrap_next(input int unsigned idx,
                                                 input int unsigned n);
        if (idx + 1 >= n) begin
            return 0;
        end
        return idx + 1;
    endfunction

endpackage : rr_mux_pkg
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter
// Description : Combinational request arbiter for rr_mux. With the macro
//               RR_MUX_ROUND_ROBIN_EN defined the search starts one past
//               `last` and wraps (round robin); otherwise the lowest-index
//               requester wins and `last` is ignored.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter
    import rr_mux_pkg::*;
#(
    parameter  int n  = 4,
    localparam int sw = $clog2(n)
) (
    input  logic [n-1:0]  in_valid,
    input  logic [sw-1:0] last,
    output logic          grant_valid,
    output logic [sw-1:0] grant_idx
);

`ifdef RR_MUX_ROUND_ROBIN_EN

    // One extra bit so start+offset can exceed n before the wrap subtract
    logic [sw-1:0] w_start;
    logic [sw:0]   w_cand;

    // Round robin: scan n candidates beginning just after the last winner
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        w_start     = sw'(rr_wrap_next(32'(last), n));
        w_cand      = '0;
        for (int i = 0; i < n; i++) begin
            w_cand = {1'b0, w_start} + (sw + 1)'(i);
            if (w_cand >= (sw + 1)'(n)) begin
                w_cand = w_cand - (sw + 1)'(n);
            end
            if (!grant_valid && in_valid[w_cand[sw-1:0]]) begin
                grant_valid = 1'b1;
                grant_idx   = w_cand[sw-1:0];
            end
        end
    end

`else

    // The pointer is still tracked by the top level but has no say here
    logic w_unused_last;
    assign w_unused_last = ^last;

    // Fixed priority: the lowest-index requesting channel wins
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        for (int i = 0; i < n; i++) begin
            if (!grant_valid && in_valid[i]) begin
                grant_valid = 1'b1;
                grant_idx   = sw'(i);
            end
        end
    end

`endif

endmodule : rr_arbiter
`default_nettype wire

// File: rtl/rr_mux.sv
`default_nettype none
// ============================================================================
// Module      : rr_mux
// Description : N-channel, w-bit valid/ready multiplexer with a registered
//               output stage. mode=0 arbitrates among requesters (policy set
//               by the macro RR_MUX_ROUND_ROBIN_EN: round robin when defined,
//               fixed priority otherwise); mode=1 forces channel `s`.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_mux
    import rr_mux_pkg::*;
#(
    parameter  int w  = 8,
    parameter  int n  = 4,
    localparam int sw = $clog2(n)
) (
    input  logic            clk,
    input  logic            rst_b,
    input  logic [n*w-1:0]  in_data,
    input  logic [n-1:0]    in_valid,
    output logic [n-1:0]    in_ready,
    input  logic            mode,
    input  logic [sw-1:0]   s,
    output logic [w-1:0]    out_data,
    output logic [sw-1:0]   out_sel,
    output logic            out_valid,
    input  logic            out_ready
);

    logic [w-1:0]  r_out_data;
    logic [sw-1:0] r_out_sel;
    logic          r_out_valid;
    logic [sw-1:0] r_last;

    logic          w_load;
    logic          w_arb_valid;
    logic [sw-1:0] w_arb_idx;
    logic          w_force_valid;
    logic          w_grant_valid;
    logic [sw-1:0] w_grant_idx;
    logic [w-1:0]  w_sel_data;

    // The output register can take a word when empty or draining this cycle.
    // Holding reset also blocks acceptance so nothing is taken while the
    // pending output is being discarded.
    assign w_load = rst_b && (!r_out_valid || out_ready);

    rr_arbiter #(
        .n (n)
    ) u_arbiter (
        .in_valid    (in_valid),
        .last        (r_last),
        .grant_valid (w_arb_valid),
        .grant_idx   (w_arb_idx)
    );

    // Forced mode: channel s qualifies only if it exists and is requesting.
    // Matching against each legal index keeps an out-of-range s from ever
    // addressing a nonexistent channel.
    always_comb begin
        w_force_valid = 1'b0;
        for (int k = 0; k < n; k++) begin
            if (s == sw'(k)) begin
                w_force_valid = in_valid[k];
            end
        end
    end

    // Final grant: pick the mode's candidate, suppressed when the output is stalled
    always_comb begin
        w_grant_valid = 1'b0;
        w_grant_idx   = w_arb_idx;
        if (mode == MODE_FORCE) begin
            w_grant_idx   = s;
            w_grant_valid = w_load && w_force_valid;
        end else begin
            w_grant_valid = w_load && w_arb_valid;
        end
    end

    // Data path mux for the granted channel
    always_comb begin
        w_sel_data = '0;
        for (int k = 0; k < n; k++) begin
            if (w_grant_idx == sw'(k)) begin
                w_sel_data = in_data[k*w +: w];
            end
        end
    end

    // Per-channel accept: at most one line high, only the granted channel
    generate
        for (genvar k = 0; k < n; k++) begin : g_ready
            assign in_ready[k] = w_grant_valid && (w_grant_idx == sw'(k));
        end
    endgenerate

    // Output register and round-robin pointer; a grant always coincides with a transfer
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_sel   <= '0;
            r_last      <= sw'(n - 1);
        end else if (w_load) begin
            if (w_grant_valid) begin
                r_out_valid <= 1'b1;
                r_out_data  <= w_sel_data;
                r_out_sel   <= w_grant_idx;
                r_last      <= w_grant_idx;
            end else begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign out_data  = r_out_data;
    assign out_sel   = r_out_sel;
    assign out_valid = r_out_valid;

endmodule : rr_mux
`default_nettype wire

// File: tb/tb_rr_mux.sv
`default_nettype none
// ============================================================================
// Module      : tb_rr_mux
// Description : Self-checking bench for rr_mux. Two instances (n=4,w=3 and
//               n=3,w=8) are compared every cycle against a behavioural
//               model; directed vectors add hand-computed expectations.
//               Follows RR_MUX_ROUND_ROBIN_EN for the expected policy.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rr_mux;

    logic clk = 1'b0;
    logic rst_b = 1'b0;
    always #5 clk = ~clk;

    // n=4, w=3 instance
    logic [11:0] d4_data   = '0;
    logic [3:0]  d4_valid  = '0;
    logic [3:0]  d4_ready;
    logic        d4_mode   = 1'b0;
    logic [1:0]  d4_s      = '0;
    logic [2:0]  d4_odata;
    logic [1:0]  d4_osel;
    logic        d4_ovalid;
    logic        d4_oready = 1'b1;

    // n=3, w=8 instance
    logic [23:0] d3_data   = '0;
    logic [2:0]  d3_valid  = '0;
    logic [2:0]  d3_ready;
    logic        d3_mode   = 1'b0;
    logic [1:0]  d3_s      = '0;
    logic [7:0]  d3_odata;
    logic [1:0]  d3_osel;
    logic        d3_ovalid;
    logic        d3_oready = 1'b1;

    rr_mux #(.w(3), .n(4)) u_dut4 (
        .clk(clk), .rst_b(rst_b), .in_data(d4_data), .in_valid(d4_valid),
        .in_ready(d4_ready), .mode(d4_mode), .s(d4_s), .out_data(d4_odata),
        .out_sel(d4_osel), .out_valid(d4_ovalid), .out_ready(d4_oready)
    );

    rr_mux #(.w(8), .n(3)) u_dut3 (
        .clk(clk), .rst_b(rst_b), .in_data(d3_data), .in_valid(d3_valid),
        .in_ready(d3_ready), .mode(d3_mode), .s(d3_s), .out_data(d3_odata),
        .out_sel(d3_osel), .out_valid(d3_ovalid), .out_ready(d3_oready)
    );

    int n_checks = 0;
    int n_pass   = 0;
    bit compare_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Which channel the rules say wins, given requests and the previous winner
    function automatic int pick(input int nn, input logic [3:0] v, input int last,
                                input logic md, input int sel, output bit ok);
        int c;
        ok = 1'b0;
        pick = 0;
        if (md) begin
            if (sel < nn && v[sel]) begin ok = 1'b1; pick = sel; end
        end else begin
`ifdef RR_MUX_ROUND_ROBIN_EN
            for (int i = 1; i <= nn; i++) begin
                c = (last + i) % nn;
                if (!ok && v[c]) begin ok = 1'b1; pick = c; end
            end
`else
            for (int i = 0; i < nn; i++) begin
                if (!ok && v[i]) begin ok = 1'b1; pick = i; end
            end
`endif
        end
    endfunction

    // Behavioural state for each instance
    bit m4_v; int m4_d, m4_sel, m4_last;
    bit m3_v; int m3_d, m3_sel, m3_last;

    always @(posedge clk or negedge rst_b) begin
        bit ok; int g;
        if (!rst_b) begin
            m4_v <= 0; m4_d <= 0; m4_sel <= 0; m4_last <= 3;
            m3_v <= 0; m3_d <= 0; m3_sel <= 0; m3_last <= 2;
        end else begin
            g = pick(4, d4_valid, m4_last, d4_mode, int'(d4_s), ok);
            if (!m4_v || d4_oready) begin
                if (ok) begin
                    m4_v <= 1; m4_d <= int'(d4_data[g*3 +: 3]); m4_sel <= g; m4_last <= g;
                end else m4_v <= 0;
            end
            g = pick(3, {1'b0, d3_valid}, m3_last, d3_mode, int'(d3_s), ok);
            if (!m3_v || d3_oready) begin
                if (ok) begin
                    m3_v <= 1; m3_d <= int'(d3_data[g*8 +: 8]); m3_sel <= g; m3_last <= g;
                end else m3_v <= 0;
            end
        end
    end

    // Every-cycle comparison against the model, away from the active edge
    always @(negedge clk) begin
        bit ok; int g; logic [3:0] exp4; logic [2:0] exp3;
        if (compare_en) begin
            g = pick(4, d4_valid, m4_last, d4_mode, int'(d4_s), ok);
            exp4 = (rst_b && (!m4_v || d4_oready) && ok) ? 4'(1 << g) : 4'd0;
            chk("m4_in_ready", 32'(d4_ready), 32'(exp4));
            chk("m4_out_valid", 32'(d4_ovalid), 32'(m4_v));
            chk("m4_out_data", 32'(d4_odata), m4_d);
            chk("m4_out_sel", 32'(d4_osel), m4_sel);
            g = pick(3, {1'b0, d3_valid}, m3_last, d3_mode, int'(d3_s), ok);
            exp3 = (rst_b && (!m3_v || d3_oready) && ok) ? 3'(1 << g) : 3'd0;
            chk("m3_in_ready", 32'(d3_ready), 32'(exp3));
            chk("m3_out_valid", 32'(d3_ovalid), 32'(m3_v));
            chk("m3_out_data", 32'(d3_odata), m3_d);
            chk("m3_out_sel", 32'(d3_osel), m3_sel);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    int exp_seq [5];

    initial begin
`ifdef RR_MUX_ROUND_ROBIN_EN
        exp_seq = '{0, 1, 2, 3, 0};
`else
        exp_seq = '{0, 0, 0, 0, 0};
`endif
        #1;
        compare_en = 1'b1;
        tick();
        tick();
        rst_b = 1'b1;
        tick();
        chk("reset_out_valid", 32'(d4_ovalid), 32'd0);
        chk("reset_out_data", 32'(d4_odata), 32'd0);
        chk("reset_out_sel", 32'(d4_osel), 32'd0);

        // Forced mode: s=2 with every channel requesting
        d4_mode = 1'b1; d4_s = 2'd2;
        d4_data = {3'b111, 3'b101, 3'b010, 3'b001};
        d4_valid = 4'b1111; d4_oready = 1'b1;
        #1 chk("force_in_ready", 32'(d4_ready), 32'b0100);
        tick();
        chk("force_out_data", 32'(d4_odata), 32'b101);
        chk("force_out_sel", 32'(d4_osel), 32'd2);
        chk("force_out_valid", 32'(d4_ovalid), 32'd1);

        // Arbitrated stream, then reset while the output holds a word
        d4_mode = 1'b0;
        tick();
        chk("stream_out_valid", 32'(d4_ovalid), 32'd1);
        rst_b = 1'b0;
        #1;
        chk("midreset_out_valid", 32'(d4_ovalid), 32'd0);
        chk("midreset_out_data", 32'(d4_odata), 32'd0);
        chk("midreset_out_sel", 32'(d4_osel), 32'd0);
        chk("midreset_in_ready", 32'(d4_ready), 32'd0);
        tick();
        rst_b = 1'b1;

        // All four requesting after reset: policy-specific grant order
        for (int i = 0; i < 5; i++) begin
            tick();
            chk($sformatf("arb_seq_%0d", i), 32'(d4_osel), 32'(exp_seq[i]));
        end

        // Backpressure: capture channel 0, then stall for five cycles
        d4_valid = 4'b0001; d4_data = {3'b000, 3'b000, 3'b000, 3'b011};
        tick();
        chk("bp_load_data", 32'(d4_odata), 32'b011);
        d4_oready = 1'b0; d4_valid = 4'b1111; d4_mode = 1'b1; d4_s = 2'd3;
        d4_data = {3'b111, 3'b110, 3'b101, 3'b100};
        for (int i = 0; i < 5; i++) begin
            #1 chk("bp_in_ready", 32'(d4_ready), 32'd0);
            tick();
            chk("bp_hold_data", 32'(d4_odata), 32'b011);
            chk("bp_hold_sel", 32'(d4_osel), 32'd0);
            chk("bp_hold_valid", 32'(d4_ovalid), 32'd1);
            d4_s = 2'(i);
        end
        // Release: drain and accept channel 1 in the same cycle
        d4_oready = 1'b1; d4_mode = 1'b0; d4_valid = 4'b0010;
        d4_data = {3'b000, 3'b000, 3'b110, 3'b000};
        #1 chk("bp_release_ready", 32'(d4_ready), 32'b0010);
        tick();
        chk("bp_release_data", 32'(d4_odata), 32'b110);
        chk("bp_release_sel", 32'(d4_osel), 32'd1);

        // Wrap-around: last=2, only channel 2 requesting
        d4_mode = 1'b1; d4_s = 2'd2; d4_valid = 4'b0100;
        d4_data = {3'b000, 3'b010, 3'b000, 3'b000};
        tick();
        d4_mode = 1'b0; d4_data = {3'b000, 3'b001, 3'b000, 3'b000};
        #1 chk("wrap_in_ready", 32'(d4_ready), 32'b0100);
        tick();
        chk("wrap_out_sel", 32'(d4_osel), 32'd2);
        chk("wrap_out_data", 32'(d4_odata), 32'b001);
        d4_valid = 4'b0000;

        // n=3: load one word, then select nonexistent channel 3
        d3_mode = 1'b1; d3_s = 2'd1; d3_valid = 3'b111;
        d3_data = {8'h3C, 8'hA5, 8'h11};
        tick();
        chk("n3_load_data", 32'(d3_odata), 32'hA5);
        chk("n3_load_valid", 32'(d3_ovalid), 32'd1);
        d3_s = 2'd3;
        #1 chk("n3_oob_ready", 32'(d3_ready), 32'd0);
        tick();
        chk("n3_oob_valid", 32'(d3_ovalid), 32'd0);
        chk("n3_oob_data_hold", 32'(d3_odata), 32'hA5);
        d3_valid = 3'b000;

        tick();
        tick();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule : tb_rr_mux
`default_nettype wire
